// File: rtl/systolic_skew_feeder_if.sv
// Bundle between the matrix loader / feed controller and the skew feeder.
//   wr_en, wr_sel, wr_idx, wr_data : row write into the A (wr_sel=0) or B (wr_sel=1) store
//   start                          : single-cycle request to begin a feed
//   a_out, b_out                   : west-edge / north-edge lanes into the PE array
//   busy, done                     : feed in progress / one-cycle end-of-drain pulse
// master = the side that loads matrices and issues start; slave = the feeder.
interface systolic_skew_feeder_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned N         = 4
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic                   wr_en;
  logic                   wr_sel;
  logic [IdxW-1:0]        wr_idx;
  logic [N*DATAWIDTH-1:0] wr_data;
  logic                   start;
  logic [N*DATAWIDTH-1:0] a_out;
  logic [N*DATAWIDTH-1:0] b_out;
  logic                   busy;
  logic                   done;

  modport master (
    output wr_en, wr_sel, wr_idx, wr_data, start,
    input  a_out, b_out, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_idx, wr_data, start,
    output a_out, b_out, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skew feeder for an NxN systolic PE array. Holds operand matrices A and B and, on start,
// streams them onto the west (a_out, lane i -> PE[i][0]) and north (b_out, lane j -> PE[0][j])
// edges with the diagonal skew the array needs, then drains for N cycles and pulses done.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears state, outputs and both matrix stores)
//   bus  : systolic_skew_feeder_if.slave (row writes, start, a_out/b_out lanes, busy, done)
module systolic_skew_feeder #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned N         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave bus
);

  localparam int unsigned CntW      = $clog2(2 * N);
  localparam int unsigned FeedLast  = 2 * N - 2;
  localparam int unsigned DrainLast = N - 1;
  localparam int unsigned RowW      = N * DATAWIDTH;

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [N-1:0][RowW-1:0] a_rows_q, a_rows_d;
  logic [N-1:0][RowW-1:0] b_rows_q, b_rows_d;
  logic [RowW-1:0]      a_out_q, a_out_d;
  logic [RowW-1:0]      b_out_q, b_out_d;
  logic                 busy_q, done_q;
  logic                 emit;
  logic [CntW-1:0]      t_next;

  // Row stores: writes land only in IDLE and only for in-range rows.
  always_comb begin
    a_rows_d = a_rows_q;
    b_rows_d = b_rows_q;
    if (state_q == StIdle && bus.wr_en && (32'(bus.wr_idx) < N)) begin
      if (bus.wr_sel) begin
        b_rows_d[bus.wr_idx] = bus.wr_data;
      end else begin
        a_rows_d[bus.wr_idx] = bus.wr_data;
      end
    end
  end

  // Next state; emit/t_next say which feed step the output registers load at this edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    emit    = 1'b0;
    t_next  = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StFeed;
          count_d = '0;
          emit    = 1'b1;
        end
      end
      StFeed: begin
        if (count_q == CntW'(FeedLast)) begin
          state_d = StDrain;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
          emit    = 1'b1;
          t_next  = count_q + 1'b1;
        end
      end
      StDrain: begin
        if (count_q == CntW'(DrainLast)) begin
          state_d = StIdle;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  // Lane i of a carries A[i][t-i]; lane j of b carries B[t-j][j]. Both reduce to "row/col
  // index plus element index equals t". Uses the post-write stores so a same-cycle write
  // and start feeds the new data.
  always_comb begin
    a_out_d = '0;
    b_out_d = '0;
    if (emit) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (32'(t_next) == i + k) begin
            a_out_d[i*DATAWIDTH +: DATAWIDTH] = a_rows_d[i][k*DATAWIDTH +: DATAWIDTH];
            b_out_d[i*DATAWIDTH +: DATAWIDTH] = b_rows_d[k][i*DATAWIDTH +: DATAWIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      a_rows_q <= '0;
      b_rows_q <= '0;
      a_out_q  <= '0;
      b_out_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_rows_q <= a_rows_d;
      b_rows_q <= b_rows_d;
      a_out_q  <= a_out_d;
      b_out_q  <= b_out_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDrain) && (count_d == CntW'(DrainLast));
    end
  end

  assign bus.a_out = a_out_q;
  assign bus.b_out = b_out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 2;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LW = N * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.DATAWIDTH(DW), .N(N)) bus ();
  systolic_skew_feeder #(.DATAWIDTH(DW), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference matrices (what the stores should hold) and a PE-array model.
  int     ma [N][N];
  int     mb [N][N];
  longint acc[N][N];
  int     pa [N][N];
  int     pb [N][N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/a_out"}, 64'(bus.a_out), 64'd0);
    chk({tag, "/b_out"}, 64'(bus.b_out), 64'd0);
    chk({tag, "/busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "/done"}, 64'(bus.done), 64'd0);
  endtask

  function automatic logic [LW-1:0] pack_row(input bit sel, input int r);
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = sel ? DW'(mb[r][k]) : DW'(ma[r][k]);
    return v;
  endfunction

  task automatic write_row(input bit sel, input int r);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_idx  = IW'(r);
    bus.wr_data = pack_row(sel, r);
    tick();
    bus.wr_en = 1'b0;
    chk_idle("write");
  endtask

  task automatic load_all();
    for (int r = 0; r < N; r++) begin
      write_row(1'b0, r);
      write_row(1'b1, r);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
  endtask

  // One clock of an NxN output-stationary PE array fed from the DUT edges.
  task automatic pe_step();
    int na[N][N];
    int nb[N][N];
    int ain, bin;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ain = int'(bus.a_out[i*DW +: DW]);
        else        ain = pa[i][j-1];
        if (i == 0) bin = int'(bus.b_out[j*DW +: DW]);
        else        bin = pb[i-1][j];
        acc[i][j] += longint'(ain) * longint'(bin);
        na[i][j] = ain;
        nb[i][j] = bin;
      end
    end
    pa = na;
    pb = nb;
  endtask

  // Called in the cycle right after the start edge. Checks every cycle from t=0 to the
  // first IDLE cycle, then checks the PE accumulators against A*B.
  task automatic run_feed(input string tag, input bit disturb);
    logic [63:0] ea, eb;
    longint      ex;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j] = 0;
        pa[i][j]  = 0;
        pb[i][j]  = 0;
      end
    for (int k = 0; k <= 3 * N - 1; k++) begin
      ea = '0;
      eb = '0;
      if (k <= 2 * N - 2) begin
        for (int l = 0; l < N; l++) begin
          if (k - l >= 0 && k - l < N) begin
            ea[l*DW +: DW] = DW'(ma[l][k-l]);
            eb[l*DW +: DW] = DW'(mb[k-l][l]);
          end
        end
      end
      chk($sformatf("%s/a_out/k%0d", tag, k), 64'(bus.a_out), ea);
      chk($sformatf("%s/b_out/k%0d", tag, k), 64'(bus.b_out), eb);
      chk($sformatf("%s/busy/k%0d", tag, k), 64'(bus.busy), (k < 3 * N - 1) ? 64'd1 : 64'd0);
      chk($sformatf("%s/done/k%0d", tag, k), 64'(bus.done), (k == 3 * N - 2) ? 64'd1 : 64'd0);
      pe_step();
      if (k == 3 * N - 1) break;
      if (disturb && k == 1) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_idx  = '0;
        bus.wr_data = {N{DW'(9)}};
      end
      if (disturb && k == 3 * N - 2) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ex = 0;
        for (int k = 0; k < N; k++) ex += longint'(ma[i][k]) * longint'(mb[k][j]);
        chk($sformatf("%s/C[%0d][%0d]", tag, i, j), 64'(acc[i][j]), 64'(ex));
      end
    end
  endtask

  task automatic set_scenario2();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_idx  = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    rst         = 1'b1;
    clear_model();

    // Reset dominates writes and start.
    bus.wr_en   = 1'b1;
    bus.wr_data = {N{DW'(8'hFF)}};
    bus.start   = 1'b1;
    tick();
    chk_idle("rst1");
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b1;
    bus.start   = 1'b1;
    tick();
    chk_idle("rst2");
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    chk_idle("post_rst");
    pulse_start();
    run_feed("zero_feed", 1'b0);

    // N=2 skew and PE integration.
    set_scenario2();
    load_all();
    pulse_start();
    run_feed("skew", 1'b0);
    chk("C00", 64'(acc[0][0]), 64'd19);
    chk("C01", 64'(acc[0][1]), 64'd22);
    chk("C10", 64'(acc[1][0]), 64'd43);
    chk("C11", 64'(acc[1][1]), 64'd50);

    // start/wr_en while busy are ignored, including start in the done cycle.
    pulse_start();
    run_feed("busy_ign", 1'b1);
    tick();
    chk_idle("no_queue");
    pulse_start();
    run_feed("replay", 1'b0);

    // Reset in the middle of FEED.
    pulse_start();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid_rst");
    clear_model();
    for (int c = 0; c < 3 * N; c++) begin
      tick();
      chk_idle("mid_rst_quiet");
    end
    pulse_start();
    run_feed("after_mid_rst", 1'b0);

    // Same-cycle write and start; then back-to-back start on the first IDLE cycle.
    set_scenario2();
    load_all();
    ma[1][0] = 7;
    ma[1][1] = 7;
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 1'b0;
    bus.wr_idx  = IW'(1);
    bus.wr_data = pack_row(1'b0, 1);
    bus.start   = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    run_feed("wr_start", 1'b0);
    pulse_start();
    run_feed("b2b", 1'b0);

    // Random matrices with random idle gaps.
    for (int rnd = 0; rnd < 6; rnd++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ma[i][j] = int'($urandom_range(0, 255));
          mb[i][j] = int'($urandom_range(0, 255));
        end
      load_all();
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
        tick();
        chk_idle("gap");
      end
      pulse_start();
      run_feed($sformatf("rand%0d", rnd), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
